// File: rtl/floo_vc_credit_out_port.sv
// Credit-based virtual-channel output port: round-robin arbitration over VCs that hold
// credits, optional wormhole lock per packet, registered link output.
package floo_vc_pkg;

  typedef struct packed {
    logic       last;
    logic [3:0] src;
  } hdr_t;

  typedef struct packed {
    hdr_t        hdr;
    logic [15:0] payload;
  } flit_t;

endpackage

module floo_vc_credit_out_port #(
  parameter int unsigned NumVirtChannels = 2,
  parameter int unsigned MaxCredits      = 4,
  parameter bit          WormholeLock    = 1'b0,
  parameter type         flit_t          = floo_vc_pkg::flit_t,
  parameter int unsigned CntWidth        = $clog2(MaxCredits + 1)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic  [NumVirtChannels-1:0]              valid_i,
  output logic  [NumVirtChannels-1:0]              ready_o,
  input  flit_t [NumVirtChannels-1:0]              data_i,
  output logic  [NumVirtChannels-1:0]              valid_o,
  output flit_t                                    data_o,
  input  logic  [NumVirtChannels-1:0]              credit_i,
  output logic  [NumVirtChannels-1:0][CntWidth-1:0] credit_cnt_o
);

  localparam int unsigned IdxWidth = (NumVirtChannels > 1) ? $clog2(NumVirtChannels) : 1;

  typedef logic [IdxWidth-1:0] vc_idx_t;
  typedef logic [CntWidth-1:0] cnt_t;

  localparam cnt_t CntMax = cnt_t'(MaxCredits);

  cnt_t [NumVirtChannels-1:0] credit_cnt_q, credit_cnt_d;
  vc_idx_t                    rr_ptr_q, rr_ptr_d;
  vc_idx_t                    lock_vc_q, lock_vc_d;
  logic                       lock_q, lock_d;
  logic [NumVirtChannels-1:0] eligible;
  logic [NumVirtChannels-1:0] grant;
  logic [NumVirtChannels-1:0] valid_q;
  vc_idx_t                    grant_idx;
  logic                       grant_any;
  flit_t                      grant_flit;
  flit_t                      data_q;

  // Credits returned this cycle only count from the next cycle on (no bypass).
  always_comb begin
    for (int unsigned v = 0; v < NumVirtChannels; v++) begin
      eligible[v] = valid_i[v] && (credit_cnt_q[v] != '0);
    end
  end

  always_comb begin : arbiter
    vc_idx_t cand;
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    if (!rst_i) begin
      if (lock_q) begin
        // A locked VC owns the link even when it has nothing to send.
        grant_idx = lock_vc_q;
        grant_any = eligible[lock_vc_q];
      end else begin
        for (int unsigned k = 0; k < NumVirtChannels; k++) begin
          cand = vc_idx_t'((32'(rr_ptr_q) + k) % NumVirtChannels);
          if (!grant_any && eligible[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
          end
        end
      end
      grant[grant_idx] = grant_any;
    end
  end

  assign grant_flit = data_i[grant_idx];

  always_comb begin : next_state
    credit_cnt_d = credit_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    lock_d       = lock_q;
    lock_vc_d    = lock_vc_q;
    for (int unsigned v = 0; v < NumVirtChannels; v++) begin
      if (grant[v] && !credit_i[v]) begin
        credit_cnt_d[v] = credit_cnt_q[v] - cnt_t'(1);
      end else if (!grant[v] && credit_i[v] && (credit_cnt_q[v] != CntMax)) begin
        credit_cnt_d[v] = credit_cnt_q[v] + cnt_t'(1);
      end
    end
    if (grant_any) begin
      if (WormholeLock && !grant_flit.hdr.last) begin
        lock_d    = 1'b1;
        lock_vc_d = grant_idx;
      end else begin
        lock_d   = 1'b0;
        rr_ptr_d = vc_idx_t'((32'(grant_idx) + 32'd1) % NumVirtChannels);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q      <= '0;
      data_q       <= '0;
      credit_cnt_q <= {NumVirtChannels{CntMax}};
      rr_ptr_q     <= '0;
      lock_q       <= 1'b0;
      lock_vc_q    <= '0;
    end else begin
      valid_q      <= grant;
      credit_cnt_q <= credit_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_q       <= lock_d;
      lock_vc_q    <= lock_vc_d;
      // The link flit holds its last value while the link idles.
      if (grant_any) begin
        data_q <= grant_flit;
      end
    end
  end

  assign ready_o      = grant;
  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign credit_cnt_o = credit_cnt_q;

  for (genvar v = 0; v < NumVirtChannels; v++) begin : g_vc_assert
    CreditOverflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(credit_i[v] && !grant[v] && (credit_cnt_q[v] == CntMax)));
    ValidHeld: assert property (@(posedge clk_i) disable iff (rst_i)
      valid_i[v] && !ready_o[v] |=> valid_i[v]);
  end

  ReadyOneHot: assert property (@(posedge clk_i) $onehot0(ready_o));
  ValidOneHot: assert property (@(posedge clk_i) $onehot0(valid_o));

endmodule

// File: tb/tb_floo_vc_credit_out_port.sv
// Bench for floo_vc_credit_out_port: an interleaving and a wormhole-locked instance, each
// compared every cycle against a queue/array model, plus directed link-order scenarios.
module tb_floo_vc_credit_out_port;
  import floo_vc_pkg::*;

  localparam int N  = 2;
  localparam int M  = 4;
  localparam int CW = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [1:0]           valid  [2];
  logic [1:0]           ready  [2];
  logic [1:0]           vo     [2];
  logic [1:0]           credit [2];
  flit_t [1:0]          din    [2];
  flit_t                dout   [2];
  logic [1:0][CW-1:0]   cnt_o  [2];

  always #5 clk = ~clk;

  floo_vc_credit_out_port #(.NumVirtChannels(N), .MaxCredits(M), .WormholeLock(1'b0)) u_interleave (
    .clk_i(clk), .rst_i(rst), .valid_i(valid[0]), .ready_o(ready[0]), .data_i(din[0]),
    .valid_o(vo[0]), .data_o(dout[0]), .credit_i(credit[0]), .credit_cnt_o(cnt_o[0]));

  floo_vc_credit_out_port #(.NumVirtChannels(N), .MaxCredits(M), .WormholeLock(1'b1)) u_lock (
    .clk_i(clk), .rst_i(rst), .valid_i(valid[1]), .ready_o(ready[1]), .data_i(din[1]),
    .valid_o(vo[1]), .data_o(dout[1]), .credit_i(credit[1]), .credit_cnt_o(cnt_o[1]));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: credits, round-robin pointer and lock owner per instance.
  bit         lock_en [2] = '{1'b0, 1'b1};
  int         m_cnt   [2][2];
  int         m_ptr   [2];
  int         m_lock  [2];
  logic [1:0] m_vo    [2];
  flit_t      m_do    [2];
  bit         acc     [2][2];

  // Stimulus state.
  bit         rnd_mode = 1'b0;
  int         left [2][2];
  int         plen [2][2];
  int         pos  [2][2];
  int         hold [2][2];
  logic [1:0] log_q [2][$];

  always @(negedge clk) begin
    int         g;
    int         v;
    logic [1:0] e;
    for (int d = 0; d < 2; d++) begin
      g = -1;
      if (!rst) begin
        if (m_lock[d] >= 0) begin
          if (valid[d][m_lock[d]] && m_cnt[d][m_lock[d]] > 0) g = m_lock[d];
        end else begin
          for (int k = 0; k < N; k++) begin
            v = (m_ptr[d] + k) % N;
            if (g < 0 && valid[d][v] && m_cnt[d][v] > 0) g = v;
          end
        end
      end
      e = (g < 0) ? 2'b00 : 2'(1 << g);
      check($sformatf("dut%0d ready", d), 64'(ready[d]), 64'(e));
      check($sformatf("dut%0d valid_o", d), 64'(vo[d]), 64'(m_vo[d]));
      check($sformatf("dut%0d data_o", d), 64'(dout[d]), 64'(m_do[d]));
      for (int c = 0; c < N; c++) begin
        check($sformatf("dut%0d cnt%0d", d, c), 64'(cnt_o[d][c]), 64'(m_cnt[d][c]));
      end
      if (rst) begin
        for (int c = 0; c < N; c++) begin
          m_cnt[d][c] = M;
          acc[d][c]   = 1'b0;
        end
        m_ptr[d]  = 0;
        m_lock[d] = -1;
        m_vo[d]   = '0;
        m_do[d]   = '0;
      end else begin
        for (int c = 0; c < N; c++) begin
          acc[d][c] = (g == c);
          if (g == c && !credit[d][c]) m_cnt[d][c]--;
          else if (g != c && credit[d][c] && m_cnt[d][c] < M) m_cnt[d][c]++;
        end
        m_vo[d] = e;
        if (g >= 0) begin
          m_do[d] = din[d][g];
          if (lock_en[d] && !din[d][g].hdr.last) begin
            m_lock[d] = g;
          end else begin
            m_lock[d] = -1;
            m_ptr[d]  = (g + 1) % N;
          end
        end
      end
    end
  end

  function automatic flit_t mk_flit(input int d, input int v);
    flit_t f;
    f.hdr.last = (pos[d][v] == plen[d][v] - 1);
    f.hdr.src  = 4'(d * 2 + v);
    f.payload  = 16'($urandom);
    return f;
  endfunction

  function automatic flit_t rand_flit(input int d, input int v);
    flit_t f;
    f.hdr.last = 1'($urandom_range(0, 1));
    f.hdr.src  = 4'(d * 2 + v);
    f.payload  = 16'($urandom);
    return f;
  endfunction

  task automatic arm(input int d, input int v, input int n, input int l);
    left[d][v]  = n;
    plen[d][v]  = l;
    pos[d][v]   = 0;
    hold[d][v]  = 0;
    din[d][v]   = mk_flit(d, v);
    valid[d][v] = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      log_q[d].push_back(vo[d]);
      for (int v = 0; v < N; v++) begin
        if (rnd_mode) begin
          credit[d][v] = (m_cnt[d][v] < M) && ($urandom_range(0, 2) == 0);
          if (acc[d][v] || !valid[d][v]) begin
            valid[d][v] = ($urandom_range(0, 3) != 0);
            din[d][v]   = rand_flit(d, v);
          end
        end else begin
          credit[d][v] = 1'b0;
          if (acc[d][v]) begin
            left[d][v]--;
            pos[d][v] = (pos[d][v] + 1) % plen[d][v];
            din[d][v] = mk_flit(d, v);
          end
          if (hold[d][v] > 0) begin
            if (acc[d][v] || !valid[d][v]) begin
              valid[d][v] = 1'b0;
              hold[d][v]--;
            end
          end else begin
            valid[d][v] = (left[d][v] != 0);
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int v = 0; v < N; v++) begin
        left[d][v]  = 0;
        hold[d][v]  = 0;
        valid[d][v] = 1'b0;
      end
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    log_q[0].delete();
    log_q[1].delete();
  endtask

  task automatic expect_log(input int d, input string name, input logic [1:0] exp[$]);
    check($sformatf("dut%0d %s length", d, name), 64'(log_q[d].size()), 64'(exp.size()));
    foreach (exp[i]) begin
      if (i < log_q[d].size()) begin
        check($sformatf("dut%0d %s[%0d]", d, name, i), 64'(log_q[d][i]), 64'(exp[i]));
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      valid[d]  = '0;
      credit[d] = '0;
      din[d]    = '0;
      m_ptr[d]  = 0;
      m_lock[d] = -1;
      m_vo[d]   = '0;
      m_do[d]   = '0;
      for (int v = 0; v < N; v++) begin
        m_cnt[d][v] = M;
        acc[d][v]   = 1'b0;
        left[d][v]  = 0;
        plen[d][v]  = 1;
        pos[d][v]   = 0;
        hold[d][v]  = 0;
      end
    end

    // Reset state, then both VCs backlogged with no credit return.
    do_reset();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d reset cnt", d), 64'(cnt_o[d]), 64'({3'd4, 3'd4}));
      check($sformatf("dut%0d reset valid_o", d), 64'(vo[d]), 64'(0));
      arm(d, 0, 20, 1);
      arm(d, 1, 20, 1);
    end
    clear_logs();
    repeat (10) tick();
    for (int d = 0; d < 2; d++) begin
      expect_log(d, "drain", '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00});
      check($sformatf("dut%0d drained cnt", d), 64'(cnt_o[d]), 64'(0));
      check($sformatf("dut%0d drained ready", d), 64'(ready[d]), 64'(0));
    end

    // VC0 out of credits; one returned credit makes it eligible one cycle later.
    do_reset();
    for (int d = 0; d < 2; d++) arm(d, 0, 6, 1);
    repeat (4) tick();
    clear_logs();
    for (int d = 0; d < 2; d++) arm(d, 1, 4, 1);
    tick();
    for (int d = 0; d < 2; d++) credit[d] = 2'b01;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d no credit bypass", d), 64'(ready[d]), 64'(2'b10));
    end
    repeat (5) tick();
    for (int d = 0; d < 2; d++) expect_log(d, "credit return", '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00});

    // Grant and credit on the same VC in the same cycle leave the count unchanged.
    do_reset();
    for (int d = 0; d < 2; d++) arm(d, 1, 3, 1);
    tick();
    tick();
    for (int d = 0; d < 2; d++) credit[d] = 2'b10;
    tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d grant+credit cnt", d), 64'(cnt_o[d][1]), 64'(2));
      credit[d] = 2'b10;
    end
    tick();
    for (int d = 0; d < 2; d++) credit[d] = 2'b10;
    tick();
    for (int d = 0; d < 2; d++) check($sformatf("dut%0d refill cnt", d), 64'(cnt_o[d][1]), 64'(4));

    // 3-flit packet on VC0 against single flits on VC1; VC0 pauses mid-packet on the locked port.
    do_reset();
    for (int d = 0; d < 2; d++) begin
      arm(d, 0, 3, 3);
      arm(d, 1, 2, 1);
    end
    hold[1][0] = 2;
    clear_logs();
    repeat (8) tick();
    expect_log(0, "interleave", '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00});
    expect_log(1, "wormhole", '{2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00});

    // Reset with a flit on the link and partially used credits.
    do_reset();
    for (int d = 0; d < 2; d++) begin
      arm(d, 0, 3, 1);
      arm(d, 1, 1, 1);
    end
    repeat (4) tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d pre-reset valid_o", d), 64'(vo[d]), 64'(2'b01));
      check($sformatf("dut%0d pre-reset cnt", d), 64'(cnt_o[d]), 64'({3'd3, 3'd1}));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d post-reset valid_o", d), 64'(vo[d]), 64'(0));
      check($sformatf("dut%0d post-reset cnt", d), 64'(cnt_o[d]), 64'({3'd4, 3'd4}));
      arm(d, 0, 1, 1);
      arm(d, 1, 1, 1);
    end
    tick();
    for (int d = 0; d < 2; d++) check($sformatf("dut%0d ptr reset first", d), 64'(vo[d]), 64'(2'b01));
    tick();
    for (int d = 0; d < 2; d++) check($sformatf("dut%0d ptr reset second", d), 64'(vo[d]), 64'(2'b10));

    // Random traffic, credit return and occasional reset, checked by the model every cycle.
    rnd_mode = 1'b1;
    repeat (3000) begin
      tick();
      rst = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
